uart_tx_buffered: RTL and testbench

Serial transmitter directly downstream of the riscv core. It consumes the core's uart_en / uart_tx_data byte strobe and buffers each byte in a small FIFO, so back-to-back stores from the single-cycle core are not lost. Each byte is serialised as an 8N1 frame on the tx line. It sits between the core top level and the board UART pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_buffered.sv | 134 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_BITS         = 8;
  localparam int DEFAULT_CLK_FREQ  = 50_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered pointers and an occupancy count.
// A write to a full FIFO is accepted only when a read happens on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // Head is read combinationally; a same-edge write lands after the old value is consumed.
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// 8N1 serial transmitter fed by a byte FIFO; tx is registered from the next-state decode.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_en,
  input  logic [DATA_BITS-1:0] uart_tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 overflow,
  output tx_state_t            state_dbg
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int BW           = $clog2(DATA_BITS);
  localparam int AW           = $clog2(FIFO_DEPTH);

  tx_state_t            state, state_nxt;
  logic [CW-1:0]        baud_cnt, baud_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 tx_nxt;

  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [AW:0]          fifo_count;
  logic                 fifo_empty;
  logic                 pop;
  logic                 push_ok;
  logic                 bit_done;

  // uart_en is a fire-and-forget strobe with no ready: a byte offered while the
  // FIFO is full and not popping on that edge is dropped and latches overflow.
  assign pop      = (state == IDLE) && !fifo_empty;
  assign push_ok  = uart_en && (!fifo_full || pop);
  assign bit_done = (baud_cnt == CW'(CLKS_PER_BIT - 1));

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_data (uart_tx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      if (uart_en && !push_ok) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    unique case (state)
      IDLE: begin
        baud_nxt = '0;
        if (pop) begin
          shift_nxt = fifo_rd_data;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_nxt = '0;
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            state_nxt = STOP;
          end else begin
            bit_nxt   = bit_idx + 1'b1;
            shift_nxt = shift >> 1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level follows the state being entered so tx changes exactly on bit boundaries.
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: 4 clocks per bit, 4-entry FIFO.
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int CPB = 4;

  logic      clk = 1'b0;
  logic      reset = 1'b0;
  logic      uart_en = 1'b0;
  logic [7:0] uart_tx_data = 8'h00;
  logic      tx;
  logic      busy;
  logic      fifo_full;
  logic      overflow;
  tx_state_t state_dbg;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rst_gen = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  uart_tx_buffered #(
    .CLK_FREQ   (16),
    .BAUD_RATE  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_en      (uart_en),
    .uart_tx_data (uart_tx_data),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    uart_en      = 1'b1;
    uart_tx_data = b;
    tick();
    uart_en      = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Called right after the strobe edge into an idle, empty FIFO; checks edges 1..40.
  task automatic check_frame(input logic [7:0] b, input string tag);
    for (int e = 1; e <= 10 * CPB; e++) begin
      tick();
      chk(tag, 32'(tx), 32'(frame_bit(b, (e - 1) / CPB)));
    end
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  // scoreboard: decode frames from the line and compare against exp_q
  initial begin : monitor
    logic       prev;
    logic       sb;
    logic       stop_b;
    logic [7:0] d;
    logic [7:0] e;
    int         gen;
    int         t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && tx === 1'b0) begin
        gen = rst_gen;
        t0  = cyc;
        @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_b = tx;
        if (gen == rst_gen) begin
          start_q.push_back(t0);
          chk("mon_start_bit", 32'(sb), 32'd0);
          chk("mon_stop_bit", 32'(stop_b), 32'd1);
          tests++;
          assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL mon_unexpected_frame: observed %02h expected no frame", d);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mon_byte", 32'(d), 32'(e));
          end
        end
      end
      prev = tx;
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    #3 reset = 1'b1;
    tick();
    tick();

    // single byte 0x55
    exp_q.push_back(8'h55);
    push(8'h55);
    chk("t1_e0_tx", 32'(tx), 32'd1);
    chk("t1_e0_busy", 32'(busy), 32'd1);
    check_frame(8'h55, "t1_line");
    chk("t1_e40_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_e41_busy", 32'(busy), 32'd0);
    chk("t1_e41_state", 32'(state_dbg), 32'(IDLE));

    // LSB-first order
    tick();
    exp_q.push_back(8'h01);
    push(8'h01);
    check_frame(8'h01, "t2_line");
    tick();
    chk("t2_busy", 32'(busy), 32'd0);

    // full FIFO with a push on the pop edge
    tick();
    exp_q.push_back(8'h11);
    push(8'h11);
    repeat (37) tick();
    chk("t3_state_stop", 32'(state_dbg), 32'(STOP));
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      push(8'h20 + 8'(i));
    end
    chk("t3_full_before", 32'(fifo_full), 32'd1);
    chk("t3_state_idle", 32'(state_dbg), 32'(IDLE));
    exp_q.push_back(8'h25);
    push(8'h25);
    chk("t3_full_after", 32'(fifo_full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd0);
    chk("t3_state_start", 32'(state_dbg), 32'(START));
    chk("t3_tx_low", 32'(tx), 32'd0);
    wait_idle(400, "t3_drain");
    chk("t3_ovf_end", 32'(overflow), 32'd0);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // burst of six strobes into a 4-entry FIFO
    tick();
    start_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    chk("t4_full_e3", 32'(fifo_full), 32'd0);
    push(8'hA4);
    chk("t4_full_e4", 32'(fifo_full), 32'd1);
    chk("t4_ovf_e4", 32'(overflow), 32'd0);
    push(8'hA5);
    chk("t4_ovf_e5", 32'(overflow), 32'd1);
    chk("t4_full_e5", 32'(fifo_full), 32'd1);
    wait_idle(400, "t4_drain");
    repeat (2) tick();
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    chk("t4_frames", 32'(start_q.size()), 32'd5);
    for (int i = 1; i < start_q.size(); i++)
      chk("t4_gap", 32'(start_q[i] - start_q[i-1]), 32'd41);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // reset during data bit 3
    tick();
    push(8'hF0);
    for (int i = 1; i <= 5; i++) push(8'(i));
    chk("t5_full_pre", 32'(fifo_full), 32'd1);
    chk("t5_ovf_pre", 32'(overflow), 32'd1);
    repeat (13) tick();
    chk("t5_bit3_tx", 32'(tx), 32'd0);
    chk("t5_bit3_state", 32'(state_dbg), 32'(DATA));
    #2;
    rst_gen++;
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk("t5_rst_tx", 32'(tx), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_full", 32'(fifo_full), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    chk("t5_rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (50) tick();
    chk("t5_post_tx", 32'(tx), 32'd1);
    chk("t5_post_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h3C);
    push(8'h3C);
    check_frame(8'h3C, "t5_line");
    tick();
    chk("t5_busy_end", 32'(busy), 32'd0);

    // idle line
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("t6_idle_tx", 32'(tx), 32'd1);
      chk("t6_idle_busy", 32'(busy), 32'd0);
    end
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    // report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
